score_bcd_converter: RTL

Sequential binary-to-BCD converter that sits between the 16-bit score counter and the seven-segment digit drivers, so the score shows as decimal instead of hex. It accepts a binary score over a valid/ready handshake and converts it with a 16-step shift-and-add-3 algorithm. It outputs five held BCD digits plus a leading-zero blanking mask for the display stage.

---
 rtl/score_bcd_converter_pkg.sv | 26 ++
 rtl/score_bcd_converter_bcd_digit_adjust.sv | 12 +
 rtl/score_bcd_converter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/score_bcd_converter_pkg.sv
// Shared types and helpers for the score binary-to-BCD converter.
package score_bcd_converter_pkg;

  typedef enum logic {IDLE = 1'b0, CONVERT = 1'b1} state_e;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_DIGITS = 5;
  localparam int MAX_DIGITS = 8;
  localparam int BCD_MAX_W  = 4 * MAX_DIGITS;

  // blank[i] is set when digit i and every digit above it are zero; the
  // ones digit is never blanked so a zero score still shows "0".
  function automatic logic [MAX_DIGITS-1:0] blank_mask(input logic [BCD_MAX_W-1:0] v,
                                                        input int digits);
    logic hi_zero;
    blank_mask = '0;
    hi_zero    = 1'b1;
    for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
      if (i < digits) begin
        hi_zero       = hi_zero && (v[4*i +: 4] == 4'd0);
        blank_mask[i] = hi_zero;
      end
    end
  endfunction

endpackage

// File: rtl/score_bcd_converter_bcd_digit_adjust.sv
// Double-dabble correction cell: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adjust
  import score_bcd_converter_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  // Digits never exceed 9 before correction, so the sum stays within 4 bits.
  assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/score_bcd_converter.sv
// Sequential shift-and-add-3 binary-to-BCD converter with held digits and
// leading-zero blanking mask for the seven-segment display stage.
module score_bcd_converter
  import score_bcd_converter_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      bin,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  generate
    if (!((64'd10 ** DIGITS) > ((64'd1 << WIDTH) - 64'd1))) begin : g_chk_digits
      $error("DIGITS too small to represent 2^WIDTH-1");
    end
    if (DIGITS > MAX_DIGITS) begin : g_chk_max
      $error("DIGITS exceeds MAX_DIGITS");
    end
  endgenerate

  state_e            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_shift;
  logic [BW-1:0]     r_scratch;
  logic [CW-1:0]     r_count;
  logic [BW-1:0]     r_bcd;
  logic [DIGITS-1:0] r_blank;
  logic              r_out_valid;

  logic [BW-1:0]       w_adj;
  logic [BW+WIDTH-1:0] w_wide;
  logic [BW-1:0]       w_scratch_nxt;
  logic [WIDTH-1:0]    w_shift_nxt;
  logic                w_done;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_digit (r_scratch[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  // One double-dabble step: correct all digits, then shift {scratch, shift} left.
  assign w_wide        = {w_adj, r_shift} << 1;
  assign w_scratch_nxt = w_wide[BW+WIDTH-1:WIDTH];
  assign w_shift_nxt   = w_wide[WIDTH-1:0];
  assign w_done        = (r_state == CONVERT) && (r_count == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_state <= IDLE;
    else if (!enable) r_state <= IDLE;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = CONVERT;
      end
      CONVERT: begin
        if (w_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift     <= '0;
      r_scratch   <= '0;
      r_count     <= '0;
      r_bcd       <= '0;
      r_blank     <= BLANK_RST;
      r_out_valid <= 1'b0;
    end else if (!enable) begin
      r_shift     <= '0;
      r_scratch   <= '0;
      r_count     <= '0;
      r_bcd       <= '0;
      r_blank     <= BLANK_RST;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_shift   <= bin;
            r_scratch <= '0;
            r_count   <= '0;
          end
        end
        CONVERT: begin
          r_scratch <= w_scratch_nxt;
          r_shift   <= w_shift_nxt;
          r_count   <= r_count + CW'(1);
          if (w_done) begin
            r_bcd       <= w_scratch_nxt;
            r_blank     <= DIGITS'(blank_mask(BCD_MAX_W'(w_scratch_nxt), DIGITS));
            r_out_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign bcd       = r_bcd;
  assign blank     = r_blank;

endmodule
